// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path.
// Holds opcodes, the FSM state enum and the mux/ALU select codes.
// No logic beyond the wait-state helper.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent stalled in a memory-wait state; flags the abort cycle.
// Latency: timeout is combinational from the current count and mem_ready.
// Backpressure: none; mem_ready in the abort cycle suppresses the timeout.
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic in_wait,
  input  logic ready,
  input  logic chg,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  assign timeout = (TIMEOUT > 0) && in_wait && !ready && (cnt == LAST);

  // Clear on state change or abort, count stalled wait cycles otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (chg || timeout) begin
      cnt <= '0;
    end else if (in_wait && !ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32 core (lw, sw, R, I, beq, jal).
// Latency: 3-5 states per instruction plus memory stall cycles.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold until mem_ready or timeout.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] AluOp,
  output logic [1:0] ResultSrc,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err
);

  state_t state, state_n;
  logic   timeout;
  logic   pcupdate, branch;

  mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .in_wait (is_wait(state)),
    .ready   (mem_ready),
    .chg     (state_n != state),
    .timeout (timeout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_n;
  end

  // Next state and control decode; everything is forced low during reset.
  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ImmSrc    = IMM_I;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    AluOp     = ALU_ADD;
    ResultSrc = RES_ALUOUT;
    retire    = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    pcupdate  = 1'b0;
    branch    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        pcupdate  = mem_ready;
        if (mem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_R:         state_n = S_EXECR;
          OP_I:         state_n = S_EXECI;
          OP_BEQ:       state_n = S_BEQ;
          OP_JAL:       state_n = S_JAL;
          default: begin
            state_n = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (op == OP_SW) begin
          ImmSrc  = IMM_S;
          state_n = S_MEMWRITE;
        end else begin
          state_n = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_n = S_MEMWB;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_n   = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        AluOp   = ALU_FUNCT;
        state_n = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
        AluOp   = ALU_FUNCT;
        state_n = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_n  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        AluOp   = ALU_SUB;
        branch  = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_4;
        pcupdate = 1'b1;
        state_n  = S_ALUWB;
      end
      default: state_n = S_FETCH;
    endcase
    // A stalled access that hits the limit is abandoned with no side effects.
    if (timeout) begin
      bus_err  = 1'b1;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      pcupdate = 1'b0;
      state_n  = S_FETCH;
    end
    PCWrite = pcupdate | (branch & zero);
    if (rst) begin
      mem_req   = 1'b0;
      MemWrite  = 1'b0;
      AdrSrc    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      RegWrite  = 1'b0;
      ImmSrc    = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      AluOp     = 2'b00;
      ResultSrc = 2'b00;
      retire    = 1'b0;
      illegal   = 1'b0;
      bus_err   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle vector bench for multicycle_controller (TIMEOUT=4).
// Each row drives one cycle of inputs and checks the full control word.
// Async reset is exercised mid-MEMWRITE by a hand-written sequence.
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, AluOp, ResultSrc;
  logic       retire, illegal, bus_err;

  multicycle_controller #(.TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AluOp(AluOp),
    .ResultSrc(ResultSrc), .retire(retire), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  logic [18:0] act;
  assign act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ImmSrc, ALUSrcA, ALUSrcB, AluOp, ResultSrc,
                retire, illegal, bus_err};

  typedef struct {
    logic        r;
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [18:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [18:0] pk(
    input logic req, mw, adr, irw, pcw, rw,
    input logic [1:0] imm, a, b, aop, res,
    input logic ret, ill, berr);
    return {req, mw, adr, irw, pcw, rw, imm, a, b, aop, res, ret, ill, berr};
  endfunction

  logic [18:0] e_zero, e_f0, e_f1, e_fto, e_dec, e_decj, e_decill;
  logic [18:0] e_malw, e_masw, e_mr, e_mrto, e_mw0, e_mw1, e_mwto, e_mwb;
  logic [18:0] e_exr, e_exi, e_awb, e_beq1, e_beq0, e_jal;

  task automatic add(input logic r, input logic [6:0] o, input logic z,
                     input logic rdy, input logic [18:0] e, input string n);
    vec_t v;
    v.r = r; v.op = o; v.z = z; v.rdy = rdy; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  task automatic check(input string n, input int idx, input logic [18:0] e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s row=%0d got=%b want=%b", n, idx, act, e);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] o, input logic z,
                      input logic rdy, input logic [18:0] e, input string n,
                      input int idx);
    @(posedge clk);
    #1;
    rst = r; op = o; zero = z; mem_ready = rdy;
    @(negedge clk);
    check(n, idx, e);
  endtask

  initial begin
    //            req mw adr irw pcw rw imm    srcA   srcB   aluop  res    ret ill berr
    e_zero   = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    e_f0     = pk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0);
    e_f1     = pk(1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0);
    e_fto    = pk(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 1);
    e_dec    = pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    e_decj   = pk(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    e_decill = pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 0, 1, 0);
    e_malw   = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    e_masw   = pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    e_mr     = pk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    e_mrto   = pk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    e_mw0    = pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    e_mw1    = pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    e_mwto   = pk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    e_mwb    = pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0);
    e_exr    = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    e_exi    = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0);
    e_awb    = pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    e_beq1   = pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1, 0, 0);
    e_beq0   = pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 1, 0, 0);
    e_jal    = pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0);

    // reset held: everything low, including mem_req
    add(1, BAD, 0, 0, e_zero, "reset");
    add(1, BAD, 0, 1, e_zero, "reset_rdy");
    // lw, 2-cycle stalls in FETCH and MEMREAD: 9 cycles
    add(0, BAD, 0, 0, e_f0,   "lw_f0");
    add(0, BAD, 0, 0, e_f0,   "lw_f1");
    add(0, BAD, 0, 1, e_f1,   "lw_f2");
    add(0, LW,  0, 0, e_dec,  "lw_dec");
    add(0, LW,  0, 0, e_malw, "lw_madr");
    add(0, BAD, 0, 0, e_mr,   "lw_mr0");
    add(0, JL,  0, 0, e_mr,   "lw_mr1");
    add(0, SW,  0, 1, e_mr,   "lw_mr2");
    add(0, BAD, 0, 0, e_mwb,  "lw_wb");
    // sw, immediate ready; ready outside wait states is ignored
    add(0, BAD, 0, 1, e_f1,   "sw_f");
    add(0, SW,  0, 1, e_dec,  "sw_dec");
    add(0, SW,  0, 1, e_masw, "sw_madr");
    add(0, LW,  0, 1, e_mw1,  "sw_mw");
    // beq taken then not taken
    add(0, BAD, 0, 1, e_f1,   "beq1_f");
    add(0, BQ,  0, 0, e_dec,  "beq1_dec");
    add(0, BAD, 1, 0, e_beq1, "beq1_ex");
    add(0, BAD, 1, 1, e_f1,   "beq0_f");
    add(0, BQ,  1, 0, e_dec,  "beq0_dec");
    add(0, BQ,  0, 0, e_beq0, "beq0_ex");
    // jal then illegal opcode
    add(0, BAD, 0, 1, e_f1,     "jal_f");
    add(0, JL,  0, 0, e_decj,   "jal_dec");
    add(0, BAD, 0, 1, e_jal,    "jal_ex");
    add(0, BAD, 0, 0, e_awb,    "jal_wb");
    add(0, BAD, 0, 1, e_f1,     "ill_f");
    add(0, BAD, 0, 0, e_decill, "ill_dec");
    add(0, BAD, 0, 0, e_f0,     "ill_back");
    // R-type and I-type
    add(0, BAD, 0, 1, e_f1,  "r_f");
    add(0, RT,  0, 0, e_dec, "r_dec");
    add(0, BAD, 0, 0, e_exr, "r_ex");
    add(0, BAD, 0, 0, e_awb, "r_wb");
    add(0, BAD, 0, 1, e_f1,  "i_f");
    add(0, IT,  0, 0, e_dec, "i_dec");
    add(0, BAD, 0, 0, e_exi, "i_ex");
    add(0, BAD, 0, 0, e_awb, "i_wb");
    // MEMREAD timeout on the 4th stalled cycle
    add(0, BAD, 0, 1, e_f1,   "to_f");
    add(0, LW,  0, 0, e_dec,  "to_dec");
    add(0, LW,  0, 0, e_malw, "to_madr");
    add(0, BAD, 0, 0, e_mr,   "to_mr0");
    add(0, BAD, 0, 0, e_mr,   "to_mr1");
    add(0, BAD, 0, 0, e_mr,   "to_mr2");
    add(0, BAD, 0, 0, e_mrto, "to_mr3");
    // FETCH timeout re-enters FETCH with a fresh count
    add(0, BAD, 0, 0, e_f0,  "fto_0");
    add(0, BAD, 0, 0, e_f0,  "fto_1");
    add(0, BAD, 0, 0, e_f0,  "fto_2");
    add(0, BAD, 0, 0, e_fto, "fto_3");
    add(0, BAD, 0, 0, e_f0,  "fre_0");
    add(0, BAD, 0, 0, e_f0,  "fre_1");
    add(0, BAD, 0, 0, e_f0,  "fre_2");
    add(0, BAD, 0, 1, e_f1,  "fre_3_rdy");
    // ready on the limit cycle wins
    add(0, LW,  0, 0, e_dec,  "win_dec");
    add(0, LW,  0, 0, e_malw, "win_madr");
    add(0, BAD, 0, 0, e_mr,   "win_mr0");
    add(0, BAD, 0, 0, e_mr,   "win_mr1");
    add(0, BAD, 0, 0, e_mr,   "win_mr2");
    add(0, BAD, 0, 1, e_mr,   "win_mr3");
    add(0, BAD, 0, 0, e_mwb,  "win_wb");
    // MEMWRITE timeout drops the write strobe
    add(0, BAD, 0, 1, e_f1,   "wto_f");
    add(0, SW,  0, 0, e_dec,  "wto_dec");
    add(0, SW,  0, 0, e_masw, "wto_madr");
    add(0, BAD, 0, 0, e_mw0,  "wto_mw0");
    add(0, BAD, 0, 0, e_mw0,  "wto_mw1");
    add(0, BAD, 0, 0, e_mw0,  "wto_mw2");
    add(0, BAD, 0, 0, e_mwto, "wto_mw3");
    add(0, BAD, 0, 0, e_f0,   "wto_back");

    foreach (tbl[i])
      step(tbl[i].r, tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].exp, tbl[i].name, i);

    // async reset in the middle of a MEMWRITE stall
    step(0, BAD, 0, 1, e_f1,   "ar_f",    1000);
    step(0, SW,  0, 0, e_dec,  "ar_dec",  1001);
    step(0, SW,  0, 0, e_masw, "ar_madr", 1002);
    step(0, BAD, 0, 0, e_mw0,  "ar_mw",   1003);
    #2;
    rst = 1'b1;
    #1;
    check("ar_async", 1004, e_zero);
    step(1, BAD, 0, 1, e_zero, "ar_hold",  1005);
    step(0, BAD, 0, 0, e_f0,   "ar_fetch", 1006);
    step(0, BAD, 0, 1, e_f1,   "ar_f1",    1007);
    step(0, RT,  0, 0, e_dec,  "ar_dec2",  1008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
